// File: rtl/uart_tx_frame.sv
// UART transmitter with a one-word holding register, 5-9 data bits, optional parity
// and 1 or 2 stop bits. Back-to-back frames leave no idle gap on the line.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Tx_DV,
    input  logic [DATA_WIDTH-1:0] i_Tx_Byte,
    output logic                  o_Tx_Ready,
    output logic                  o_Tx_Serial,
    output logic                  o_Tx_Active,
    output logic                  o_Tx_Done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_tx_frame: DATA_WIDTH must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam bit HAS_PARITY = (PARITY != 0);
    localparam bit ODD_PARITY = (PARITY == 2);
    localparam bit TWO_STOP   = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_reg;
    logic                    hold_full_reg;
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    parity_reg;
    logic [CNT_W-1:0]        clk_cnt_reg;
    logic [IDX_W-1:0]        bit_idx_reg;
    logic                    stop_idx_reg;
    logic                    serial_reg;
    logic                    active_reg;
    logic                    done_reg;

    logic bit_end;
    logic stop_last;
    logic frame_end;
    logic load_now;
    logic parity_next;

    assign bit_end     = (clk_cnt_reg == CNT_LAST);
    assign stop_last   = (stop_idx_reg == TWO_STOP);
    assign frame_end   = (state_reg == S_STOP) && bit_end && stop_last;
    // The shifter only drains the holding register from IDLE or at the very end of a frame.
    assign load_now    = hold_full_reg && ((state_reg == S_IDLE) || frame_end);
    assign parity_next = (^hold_reg) ^ ODD_PARITY;

    assign o_Tx_Ready  = !hold_full_reg;
    assign o_Tx_Serial = serial_reg;
    assign o_Tx_Active = active_reg;
    assign o_Tx_Done   = done_reg;

    // Fill needs an empty register and drain needs a full one, so they never collide.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            hold_full_reg <= 1'b0;
            hold_reg      <= '0;
        end else if (load_now) begin
            hold_full_reg <= 1'b0;
        end else if (i_Tx_DV && !hold_full_reg) begin
            hold_full_reg <= 1'b1;
            hold_reg      <= i_Tx_Byte;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_reg    <= S_IDLE;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            clk_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            serial_reg   <= 1'b1;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            // Registered pulse: raised one edge early so it covers the final stop cycle.
            done_reg <= (state_reg == S_STOP) && stop_last && (clk_cnt_reg == CNT_DONE);
            if (load_now) begin
                shift_reg    <= hold_reg;
                parity_reg   <= parity_next;
                state_reg    <= S_START;
                clk_cnt_reg  <= '0;
                bit_idx_reg  <= '0;
                stop_idx_reg <= 1'b0;
                serial_reg   <= 1'b0;
                active_reg   <= 1'b1;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        serial_reg <= 1'b1;
                    end
                    S_START: begin
                        if (bit_end) begin
                            clk_cnt_reg <= '0;
                            bit_idx_reg <= '0;
                            serial_reg  <= shift_reg[0];
                            state_reg   <= S_DATA;
                        end else begin
                            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            clk_cnt_reg <= '0;
                            if (bit_idx_reg == IDX_LAST) begin
                                bit_idx_reg <= '0;
                                if (HAS_PARITY) begin
                                    serial_reg <= parity_reg;
                                    state_reg  <= S_PARITY;
                                end else begin
                                    serial_reg   <= 1'b1;
                                    stop_idx_reg <= 1'b0;
                                    state_reg    <= S_STOP;
                                end
                            end else begin
                                bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                                shift_reg   <= shift_reg >> 1;
                                serial_reg  <= shift_reg[1];
                            end
                        end else begin
                            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            clk_cnt_reg  <= '0;
                            serial_reg   <= 1'b1;
                            stop_idx_reg <= 1'b0;
                            state_reg    <= S_STOP;
                        end else begin
                            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            clk_cnt_reg <= '0;
                            if (stop_last) begin
                                stop_idx_reg <= 1'b0;
                                serial_reg   <= 1'b1;
                                active_reg   <= 1'b0;
                                state_reg    <= S_IDLE;
                            end else begin
                                stop_idx_reg <= 1'b1;
                            end
                        end else begin
                            clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_reg  <= S_IDLE;
                        serial_reg <= 1'b1;
                        active_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three parameter sets checked cycle by cycle against a
// frame-level model, plus decoded frames compared with hand-computed bit patterns.
module tb_uart_tx_frame;

    localparam int NI = 3;
    localparam int C_OF   [NI] = '{87, 4, 4};
    localparam int DW_OF  [NI] = '{8, 7, 8};
    localparam int PAR_OF [NI] = '{0, 2, 1};
    localparam int SB_OF  [NI] = '{1, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] dv;
    logic [8:0] din [NI];
    logic [2:0] ready, serial, active, done;

    int checks = 0;
    int passed = 0;

    uart_tx_frame u0 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(din[0][7:0]),
        .o_Tx_Ready(ready[0]), .o_Tx_Serial(serial[0]), .o_Tx_Active(active[0]), .o_Tx_Done(done[0])
    );
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_WIDTH(7), .PARITY(2), .STOP_BITS(2)) u1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(din[1][6:0]),
        .o_Tx_Ready(ready[1]), .o_Tx_Serial(serial[1]), .o_Tx_Active(active[1]), .o_Tx_Done(done[1])
    );
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(din[2][7:0]),
        .o_Tx_Ready(ready[2]), .o_Tx_Serial(serial[2]), .o_Tx_Active(active[2]), .o_Tx_Done(done[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Frame as a list of line levels, index 0 = start bit.
    function automatic logic [15:0] frame_of(input int k, input logic [8:0] w);
        logic [15:0] f;
        int n;
        bit p;
        f = 16'hFFFF;
        n = 0;
        p = 1'b0;
        f[n] = 1'b0;
        n++;
        for (int i = 0; i < DW_OF[k]; i++) begin
            f[n] = w[i];
            p = p ^ w[i];
            n++;
        end
        if (PAR_OF[k] != 0) begin
            f[n] = (PAR_OF[k] == 2) ? ~p : p;
        end
        return f;
    endfunction

    function automatic int nbits_of(input int k);
        return 1 + DW_OF[k] + ((PAR_OF[k] != 0) ? 1 : 0) + SB_OF[k];
    endfunction

    bit          m_full [NI];
    logic [8:0]  m_word [NI];
    bit          m_busy [NI];
    logic [15:0] m_frame[NI];
    int          m_pos  [NI];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                m_full[k] <= 1'b0;
                m_busy[k] <= 1'b0;
                m_pos[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (m_busy[k] && m_pos[k] != nbits_of(k) * C_OF[k] - 1) begin
                    m_pos[k] <= m_pos[k] + 1;
                end else if (m_full[k]) begin
                    m_frame[k] <= frame_of(k, m_word[k]);
                    m_pos[k]   <= 0;
                    m_busy[k]  <= 1'b1;
                    m_full[k]  <= 1'b0;
                end else begin
                    m_busy[k] <= 1'b0;
                end
                if (dv[k] && !m_full[k]) begin
                    m_full[k] <= 1'b1;
                    m_word[k] <= din[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            logic es;
            es = m_busy[k] ? m_frame[k][m_pos[k] / C_OF[k]] : 1'b1;
            check($sformatf("serial%0d", k), 32'(serial[k]), 32'(es));
            check($sformatf("active%0d", k), 32'(active[k]), 32'(m_busy[k]));
            check($sformatf("done%0d", k), 32'(done[k]),
                  32'(m_busy[k] && (m_pos[k] == nbits_of(k) * C_OF[k] - 1)));
            check($sformatf("ready%0d", k), 32'(ready[k]), 32'(!m_full[k]));
        end
    end

    bit          mon_in  [NI];
    int          mon_cyc [NI];
    logic [15:0] mon_bits[NI];
    int          act_cnt [NI];
    int          done_cnt[NI];
    int          fall_cnt[NI];
    bit          prev_act[NI];
    logic [15:0] rxq0[$], rxq1[$], rxq2[$];

    // Line decoder: samples each bit at its midpoint and queues whole frames.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            logic [15:0] b;
            act_cnt[k]  <= act_cnt[k] + int'(active[k]);
            done_cnt[k] <= done_cnt[k] + int'(done[k]);
            fall_cnt[k] <= fall_cnt[k] + int'(prev_act[k] && !active[k]);
            prev_act[k] <= active[k];
            if (rst) begin
                mon_in[k] <= 1'b0;
            end else if (!mon_in[k]) begin
                if (serial[k] == 1'b0) begin
                    mon_in[k]   <= 1'b1;
                    mon_cyc[k]  <= 1;
                    mon_bits[k] <= '0;
                end
            end else begin
                b = mon_bits[k];
                if (mon_cyc[k] % C_OF[k] == C_OF[k] / 2) b[mon_cyc[k] / C_OF[k]] = serial[k];
                if (mon_cyc[k] == (nbits_of(k) - 1) * C_OF[k] + C_OF[k] / 2) begin
                    case (k)
                        0: rxq0.push_back(b);
                        1: rxq1.push_back(b);
                        default: rxq2.push_back(b);
                    endcase
                    mon_in[k] <= 1'b0;
                end else begin
                    mon_bits[k] <= b;
                    mon_cyc[k]  <= mon_cyc[k] + 1;
                end
            end
        end
    end

    function automatic int qsize(input int k);
        case (k)
            0: return rxq0.size();
            1: return rxq1.size();
            default: return rxq2.size();
        endcase
    endfunction

    task automatic qpop(input int k, output logic [15:0] v);
        case (k)
            0: v = rxq0.pop_front();
            1: v = rxq1.pop_front();
            default: v = rxq2.pop_front();
        endcase
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic send(input int k, input logic [8:0] w, input bit keep);
        int n;
        n = 0;
        dv[k]  = 1'b1;
        din[k] = w;
        while (m_full[k] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (m_full[k]) begin
            checks++;
            $display("FAIL send%0d_timeout: holding register stayed full, required accept of %h", k, w);
        end
        @(negedge clk);
        if (!keep) dv[k] = 1'b0;
    endtask

    task automatic wait_rx(input int k, input logic [15:0] exp, input string name);
        int n;
        logic [15:0] got;
        n = 0;
        while (qsize(k) == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (qsize(k) == 0) begin
            checks++;
            $display("FAIL %s: no frame decoded, required %h", name, exp);
        end else begin
            qpop(k, got);
            check(name, 32'(got), 32'(exp));
        end
    endtask

    int a0, d0, f0;

    initial begin
        rst = 1'b1;
        dv  = '0;
        for (int k = 0; k < NI; k++) din[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_serial", 32'(serial), 32'h7);
        check("rst_active", 32'(active), 32'h0);
        check("rst_done",   32'(done),   32'h0);
        check("rst_ready",  32'(ready),  32'h7);
        rst = 1'b0;
        @(negedge clk);

        // 0x55, defaults: alternating line, 870 active cycles, one Done pulse
        a0 = act_cnt[0];
        d0 = done_cnt[0];
        send(0, 9'h055, 1'b0);
        wait_rx(0, 16'h02AA, "t1_frame_55");
        repeat (100) @(negedge clk);
        check("t1_active_cycles", 32'(act_cnt[0] - a0), 32'd870);
        check("t1_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

        // 7 data bits, odd parity, two stops, 4 clk/bit
        a0 = act_cnt[1];
        d0 = done_cnt[1];
        send(1, 9'h003, 1'b0);
        wait_rx(1, 16'h0706, "t2_frame_03");
        repeat (20) @(negedge clk);
        check("t2_active_cycles", 32'(act_cnt[1] - a0), 32'd44);
        check("t2_done_pulses", 32'(done_cnt[1] - d0), 32'd1);

        // even parity
        send(2, 9'h0FF, 1'b0);
        wait_rx(2, 16'h05FE, "t3_frame_ff");
        send(2, 9'h001, 1'b0);
        wait_rx(2, 16'h0602, "t3_frame_01");
        repeat (20) @(negedge clk);

        // back-to-back with DV held
        f0 = fall_cnt[0];
        send(0, 9'h0A5, 1'b1);
        send(0, 9'h03C, 1'b0);
        check("t4_ready_low", 32'(ready[0]), 32'd0);
        wait_rx(0, 16'h034A, "t4_frame_a5");
        wait_rx(0, 16'h0278, "t4_frame_3c");
        repeat (100) @(negedge clk);
        check("t4_active_falls", 32'(fall_cnt[0] - f0), 32'd1);

        // asynchronous reset mid-data with a word waiting in the holding register
        send(0, 9'h0F0, 1'b0);
        send(0, 9'h00F, 1'b0);
        repeat (261) @(negedge clk);
        check("t5_active_before", 32'(active[0]), 32'd1);
        check("t5_ready_before", 32'(ready[0]), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t5_serial_async", 32'(serial[0]), 32'd1);
        check("t5_active_async", 32'(active[0]), 32'd0);
        check("t5_ready_async", 32'(ready[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t5_no_partial_frame", 32'(qsize(0)), 32'd0);
        send(0, 9'h081, 1'b0);
        wait_rx(0, 16'h0302, "t5_frame_81");
        repeat (100) @(negedge clk);

        // DV while not ready is ignored
        send(0, 9'h012, 1'b0);
        send(0, 9'h034, 1'b0);
        dv[0]  = 1'b1;
        din[0] = 9'h077;
        repeat (20) @(negedge clk);
        check("t6_ready_low", 32'(ready[0]), 32'd0);
        dv[0] = 1'b0;
        wait_rx(0, 16'h0224, "t6_frame_12");
        wait_rx(0, 16'h0268, "t6_frame_34");
        repeat (1000) @(negedge clk);
        check("t6_no_extra_frame", 32'(qsize(0)), 32'd0);
        check("t6_line_idle", 32'(serial[0]), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
